zeroheti_apb_mgr: RTL and testbench

APB manager (requester) that converts a simple valid/ready request/response interface into APB3 transfers toward the peripheral demux, i.e. the initiating end of the bus our APB peripherals (UART, mtimer) respond to. Intended for non-core bus masters, such as a debug or DMA-style agent, that need to reach the APB peripheral space without a core. One transfer is outstanding at a time. A programmable timeout terminates transfers whose responder never asserts `pready`.

---
 rtl/zeroheti_pkg.sv | 17 +
 rtl/zeroheti_apb_mgr.sv | 89 ++++++++
 tb/tb_zeroheti_apb_mgr.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/zeroheti_pkg.sv
// zeroheti_pkg: shared types for the zeroheti APB manager and core configuration.
package zeroheti_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mgr_state_e;

   typedef struct packed {
      logic [7:0] apb_mgr_timeout;
   } core_cfg_t;

   localparam core_cfg_t DefaultCoreCfg = '{apb_mgr_timeout: 8'd255};

   // A zero timeout still needs a one-bit counter to keep the wait logic well formed.
   function automatic int unsigned apb_mgr_cnt_width(input int unsigned t);
      return (t == 0) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/zeroheti_apb_mgr.sv
// zeroheti_apb_mgr: valid/ready request to APB3 requester with one outstanding transfer and wait timeout.
module zeroheti_apb_mgr
   import zeroheti_pkg::*;
#(
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_write_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [DataWidth-1:0] req_wdata_i,
   output logic                 resp_valid_o,
   input  logic                 resp_ready_i,
   output logic [DataWidth-1:0] resp_rdata_o,
   output logic                 resp_err_o,
   output logic                 resp_timeout_o,
   output logic                 psel_o,
   output logic                 penable_o,
   output logic                 pwrite_o,
   output logic [AddrWidth-1:0] paddr_o,
   output logic [DataWidth-1:0] pwdata_o,
   input  logic [DataWidth-1:0] prdata_i,
   input  logic                 pready_i,
   input  logic                 pslverr_i
);

   localparam int unsigned     CntW      = apb_mgr_cnt_width(TimeoutCycles);
   localparam logic [CntW-1:0] CntMax    = CntW'(TimeoutCycles);
   localparam bit              TimeoutEn = (TimeoutCycles != 0);

   apb_mgr_state_e  state, state_next;
   logic [CntW-1:0] cnt;
   logic            expire, done;

   assign expire      = TimeoutEn && !pready_i && (cnt == CntMax);
   assign done        = (state == ACCESS) && (pready_i || expire);
   assign req_ready_o = (state == IDLE);
   assign psel_o      = (state == SETUP) || (state == ACCESS);
   assign penable_o   = (state == ACCESS);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = req_valid_i ? SETUP : IDLE;
         SETUP:   state_next = ACCESS;
         ACCESS:  state_next = (pready_i || expire) ? RESP : ACCESS;
         RESP:    state_next = resp_ready_i ? IDLE : RESP;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_next;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pwrite_o       <= 1'b0;
         paddr_o        <= '0;
         pwdata_o       <= '0;
         cnt            <= '0;
         resp_valid_o   <= 1'b0;
         resp_rdata_o   <= '0;
         resp_err_o     <= 1'b0;
         resp_timeout_o <= 1'b0;
      end else begin
         if (state == IDLE && req_valid_i) begin
            pwrite_o <= req_write_i;
            paddr_o  <= req_addr_i;
            pwdata_o <= req_wdata_i;
         end
         // Saturating so a disabled timeout cannot wrap on a hung responder.
         if (state == ACCESS && !pready_i && cnt != '1) cnt <= cnt + CntW'(1);
         if (state == RESP && resp_ready_i) cnt <= '0;
         if (done) begin
            resp_rdata_o   <= (pready_i && !pwrite_o) ? prdata_i : '0;
            resp_err_o     <= pready_i ? pslverr_i : 1'b1;
            resp_timeout_o <= !pready_i;
         end
         resp_valid_o <= (state_next == RESP);
      end
   end

endmodule

// File: tb/tb_zeroheti_apb_mgr.sv
// tb_zeroheti_apb_mgr: scoreboard bench for the APB manager with a short timeout.
module tb_zeroheti_apb_mgr;

   localparam int Tmo = 4;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        resp_valid, resp_ready = 1'b0, resp_err, resp_timeout;
   logic [31:0] resp_rdata;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata = '0;
   logic        pready = 1'b0, pslverr = 1'b0;

   int n_chk = 0, n_err = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        to;
   } resp_t;

   resp_t sb[$];

   always #5 clk = ~clk;

   zeroheti_apb_mgr #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(Tmo)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
      .resp_err_o(resp_err), .resp_timeout_o(resp_timeout),
      .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
      .paddr_o(paddr), .pwdata_o(pwdata),
      .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called and returns at a negedge; waits < 0 or > Tmo means the responder never answers.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits,
                       input logic serr, input logic [31:0] prd, input int hold, input bit pend);
      int    acc;
      bit    to;
      resp_t e, exp_r;
      logic [33:0] held;
      to = (waits < 0) || (waits > Tmo);
      e.to = to;
      e.err = to || serr;
      e.rdata = (w || to) ? 32'h0 : prd;
      sb.push_back(e);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      prdata = prd; pslverr = serr;
      @(negedge clk);
      req_valid = 1'b0;
      chk("setup_ctl", {psel, penable, pwrite}, {1'b1, 1'b0, w});
      chk("setup_paddr", paddr, a);
      chk("setup_pwdata", pwdata, d);
      acc = 0;
      @(negedge clk);
      while (!resp_valid && acc < 20) begin
         chk("access_ctl", {psel, penable, pwrite}, {1'b1, 1'b1, w});
         chk("access_paddr", paddr, a);
         chk("access_pwdata", pwdata, d);
         pready = (acc == waits);
         acc++;
         @(negedge clk);
      end
      pready = 1'b0;
      chk("access_cycles", acc, to ? Tmo + 1 : waits + 1);
      chk("resp_valid", resp_valid, 1);
      chk("resp_apb_idle", {psel, penable}, 2'b00);
      held = {resp_rdata, resp_err, resp_timeout};
      repeat (hold) begin
         chk("backpressure", {resp_valid, req_ready, resp_rdata, resp_err, resp_timeout}, {1'b1, 1'b0, held});
         @(negedge clk);
      end
      resp_ready = 1'b1;
      if (pend) begin
         req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0003_0008;
      end
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
         exp_r = sb.pop_front();
         chk("resp_rdata", resp_rdata, exp_r.rdata);
         chk("resp_err", resp_err, exp_r.err);
         chk("resp_timeout", resp_timeout, exp_r.to);
      end
      chk("req_ready_in_resp", req_ready, 0);
      @(negedge clk);
      resp_ready = 1'b0;
      chk("after_handshake", {resp_valid, req_ready}, 2'b01);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge clk);
      chk("rst_ctl", {req_ready, psel, penable, pwrite, resp_valid, resp_err, resp_timeout}, 7'b1000000);
      chk("rst_data", {paddr, pwdata, resp_rdata}, '0);
      rst_n = 1'b1;
      @(negedge clk);
      xfer(1'b0, 32'h0003_0004, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
      xfer(1'b1, 32'h0003_0000, 32'h1234_5678, 3, 1'b0, 32'hA5A5_A5A5, 0, 1'b0);
      xfer(1'b0, 32'h0003_0010, 32'h0, 1, 1'b1, 32'hCAFE_F00D, 0, 1'b0);
      xfer(1'b0, 32'h0003_0020, 32'h0, -1, 1'b0, 32'h1111_2222, 0, 1'b0);
      xfer(1'b0, 32'h0003_0024, 32'h0, Tmo, 1'b0, 32'h3333_4444, 0, 1'b0);
      xfer(1'b1, 32'h0003_0030, 32'hABCD_0123, 0, 1'b0, 32'h0, 10, 1'b1);
      xfer(1'b0, 32'h0003_0008, 32'h0, 2, 1'b0, 32'h5566_7788, 0, 1'b0);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0003_0040;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_reset_access", {psel, penable}, 2'b11);
      rst_n = 1'b0;
      #1;
      chk("reset_async", {psel, penable, req_ready}, 3'b001);
      repeat (2) begin
         @(negedge clk);
         chk("reset_hold", {psel, penable, req_ready, resp_valid}, 4'b0010);
      end
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         chk("post_reset", {psel, resp_valid, req_ready}, 3'b001);
      end
      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
